// File: rtl/enc_preset_ctrl.sv
// Rotary-encoder preset controller: quadrature decode, detent accumulation and a press-driven
// SET_MIN/SET_SEC/ARMED state machine. Define ENC_ACCEL_EN to enable fast-turn acceleration.
module enc_preset_ctrl #(
    parameter int QPD       = 4,
    parameter int ACCEL_WIN = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       BTN,
    output logic [5:0] min_o,
    output logic [5:0] sec_o,
    output logic       load_o,
    output logic [1:0] state_o,
    output logic [1:0] LED
);

    typedef enum logic [1:0] {
        SET_MIN = 2'd0,
        SET_SEC = 2'd1,
        ARMED   = 2'd2
    } state_t;

    localparam logic signed [4:0] QPD_S = 5'(QPD);

    if (QPD < 1 || QPD > 7 || ACCEL_WIN < 1 || ACCEL_WIN > 4194303) begin : gBadParams
        $error("enc_preset_ctrl: QPD or ACCEL_WIN out of range");
    end

    logic [1:0]        ab_q;
    logic              btn_q;
    logic              primed_q;
    logic signed [4:0] acc_q;
    logic signed [4:0] acc_d;
    logic signed [4:0] accSum;
    logic signed [4:0] step;
    logic [1:0]        posOld;
    logic [1:0]        posNew;
    logic [1:0]        posDiff;
    logic              hitCw;
    logic              hitCcw;
    logic              press;
    logic              detentCw_q;
    logic              detentCcw_q;
    logic              press_q;

    state_t            state_q, state_d;
    logic [5:0]        min_q, min_d;
    logic [5:0]        sec_q, sec_d;
    logic [1:0]        led_q, led_d;
    logic              load_q, load_d;
    logic [5:0]        delta;

    // Gray code to position index, so a +1 / -1 index difference is a CW / CCW quarter-step.
    function automatic logic [1:0] grayPos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    function automatic logic [5:0] addMod60(input logic [5:0] v, input logic [5:0] d);
        logic [6:0] s;
        s = {1'b0, v} + {1'b0, d};
        return (s >= 7'd60) ? 6'(s - 7'd60) : s[5:0];
    endfunction

    function automatic logic [5:0] subMod60(input logic [5:0] v, input logic [5:0] d);
        logic [6:0] s;
        s = {1'b0, v} + 7'd60 - {1'b0, d};
        return (s >= 7'd60) ? 6'(s - 7'd60) : s[5:0];
    endfunction

    always_comb begin
        posOld  = grayPos(ab_q);
        posNew  = grayPos({A, B});
        posDiff = posNew - posOld;
        step    = '0;
        if (primed_q) begin
            case (posDiff)
                2'd1:    step = 5'sd1;
                2'd3:    step = -5'sd1;
                default: step = '0;
            endcase
        end
        accSum = acc_q + step;
        hitCw  = (accSum == QPD_S);
        hitCcw = (accSum == -QPD_S);
        acc_d  = (hitCw || hitCcw) ? '0 : accSum;
        press  = primed_q && BTN && !btn_q;
    end

    // primed_q keeps the first post-reset sample of A/B/BTN from looking like a step or press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ab_q        <= 2'b00;
            btn_q       <= 1'b0;
            primed_q    <= 1'b0;
            acc_q       <= '0;
            detentCw_q  <= 1'b0;
            detentCcw_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            ab_q        <= {A, B};
            btn_q       <= BTN;
            primed_q    <= 1'b1;
            acc_q       <= acc_d;
            detentCw_q  <= hitCw;
            detentCcw_q <= hitCcw;
            press_q     <= press;
        end
    end

`ifdef ENC_ACCEL_EN
    localparam logic [21:0] WIN_RELOAD = 22'(ACCEL_WIN - 1);

    logic [21:0] win_q, win_d;
    logic        accept;

    // Down-counter: non-zero means the previous accepted detent is still inside the window.
    assign accept = (detentCw_q || detentCcw_q) && !press_q && (state_q != ARMED);
    assign delta  = (win_q != '0) ? 6'd5 : 6'd1;

    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d = WIN_RELOAD;
        end else if (win_q != '0) begin
            win_d = win_q - 22'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end
`else
    assign delta = 6'd1;
`endif

    // A press outranks a detent arriving in the same cycle; LED still records that detent.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        led_d   = led_q;
        load_d  = 1'b0;
        if (detentCw_q) begin
            led_d = 2'b01;
        end else if (detentCcw_q) begin
            led_d = 2'b10;
        end
        if (press_q) begin
            case (state_q)
                SET_MIN: state_d = SET_SEC;
                SET_SEC: state_d = ARMED;
                ARMED: begin
                    state_d = SET_MIN;
                    load_d  = 1'b1;
                end
                default: state_d = SET_MIN;
            endcase
        end else if (detentCw_q || detentCcw_q) begin
            case (state_q)
                SET_MIN: min_d = detentCw_q ? addMod60(min_q, delta) : subMod60(min_q, delta);
                SET_SEC: sec_d = detentCw_q ? addMod60(sec_q, delta) : subMod60(sec_q, delta);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SET_MIN;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            led_q   <= 2'b00;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            led_q   <= led_d;
            load_q  <= load_d;
        end
    end

    assign min_o   = min_q;
    assign sec_o   = sec_q;
    assign load_o  = load_q;
    assign state_o = state_q;
    assign LED     = led_q;

endmodule

// File: tb/tb_enc_preset_ctrl.sv
// Bench for enc_preset_ctrl: a behavioural model pushes expected snapshots to a queue that is
// popped and compared once the two-stage DUT pipeline has produced its outputs.
module tb_enc_preset_ctrl;

    localparam int QPD = 4;
    localparam int WIN = 100;
`ifdef ENC_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    typedef struct {
        int minV;
        int secV;
        int stateV;
        int ledV;
        int loadV;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       BTN = 1'b0;
    logic [5:0] minO;
    logic [5:0] secO;
    logic       loadO;
    logic [1:0] stateO;
    logic [1:0] ledO;

    int    total = 0;
    int    bad = 0;
    int    cycleCnt = 0;
    int    loadCount = 0;
    int    expLoads = 0;
    int    abIdx = 0;
    int    mMin = 0;
    int    mSec = 0;
    int    mState = 0;
    int    mLed = 0;
    int    lastAcc = -1;
    snap_t expQ[$];

    enc_preset_ctrl #(.QPD(QPD), .ACCEL_WIN(WIN)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .BTN(BTN),
        .min_o(minO), .sec_o(secO), .load_o(loadO), .state_o(stateO), .LED(ledO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(negedge clk) if (loadO) loadCount <= loadCount + 1;

    function automatic logic [1:0] grayOf(input int idx);
        case (idx % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int mod60(input int v);
        return ((v % 60) + 60) % 60;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveQuarter(input int dir);
        @(negedge clk);
        abIdx = (abIdx + dir + 4) % 4;
        {A, B} = grayOf(abIdx);
    endtask

    task automatic modelReset();
        mMin = 0;
        mSec = 0;
        mState = 0;
        mLed = 0;
        lastAcc = -1;
    endtask

    // kind: 0 = detent, 1 = press, 2 = press together with a detent-completing quarter-step
    task automatic modelEvent(input int kind, input int dir, input int e1);
        snap_t s;
        int    stepSize;
        s.loadV = 0;
        if (kind != 1) mLed = (dir > 0) ? 1 : 2;
        if (kind != 0) begin
            if (mState == 2) begin
                s.loadV = 1;
                expLoads++;
            end
            mState = (mState + 1) % 3;
        end else if (mState != 2) begin
            stepSize = (ACCEL && lastAcc >= 0 && (e1 - lastAcc) < WIN) ? 5 : 1;
            lastAcc = e1;
            if (mState == 0) mMin = mod60(mMin + dir * stepSize);
            else             mSec = mod60(mSec + dir * stepSize);
        end
        s.minV = mMin;
        s.secV = mSec;
        s.stateV = mState;
        s.ledV = mLed;
        expQ.push_back(s);
    endtask

    task automatic compareNext(input string tag);
        snap_t s;
        checkOutput({tag, "_queued"}, expQ.size(), 1);
        if (expQ.size() > 0) begin
            s = expQ.pop_front();
            checkOutput({tag, "_min"}, int'(minO), s.minV);
            checkOutput({tag, "_sec"}, int'(secO), s.secV);
            checkOutput({tag, "_state"}, int'(stateO), s.stateV);
            checkOutput({tag, "_led"}, int'(ledO), s.ledV);
            checkOutput({tag, "_load"}, int'(loadO), s.loadV);
        end
    endtask

    task automatic checkSettled(input string tag);
        idle(2);
        checkOutput({tag, "_min"}, int'(minO), mMin);
        checkOutput({tag, "_sec"}, int'(secO), mSec);
        checkOutput({tag, "_state"}, int'(stateO), mState);
    endtask

    task automatic applyStimulus(input string tag, input int kind, input int dir, input int nPre);
        if (kind != 1) begin
            for (int i = 0; i < nPre; i++) driveQuarter(dir);
        end
        @(negedge clk);
        modelEvent(kind, dir, cycleCnt + 2);
        if (kind != 1) begin
            abIdx = (abIdx + dir + 4) % 4;
            {A, B} = grayOf(abIdx);
        end
        if (kind != 0) BTN = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        compareNext(tag);
        @(negedge clk);
        checkOutput({tag, "_loadoff"}, int'(loadO), 0);
        if (kind != 0) begin
            idle(3);
            checkOutput({tag, "_once"}, int'(stateO), mState);
            BTN = 1'b0;
        end
    endtask

    initial begin
        idle(3);
        checkOutput("rst_min", int'(minO), 0);
        checkOutput("rst_sec", int'(secO), 0);
        checkOutput("rst_state", int'(stateO), 0);
        checkOutput("rst_led", int'(ledO), 0);
        checkOutput("rst_load", int'(loadO), 0);
        reset = 1'b1;
        idle(2);

        applyStimulus("cw1", 0, 1, QPD - 1);
        applyStimulus("ccw_to0", 0, -1, QPD - 1);
        applyStimulus("ccw_wrap", 0, -1, QPD - 1);
        applyStimulus("cw_wrap", 0, 1, QPD - 1);

        // Back-and-forth plus a both-bits jump must leave the accumulator at zero.
        for (int i = 0; i < 3; i++) driveQuarter(1);
        @(negedge clk);
        abIdx = (abIdx + 2) % 4;
        {A, B} = grayOf(abIdx);
        for (int i = 0; i < 3; i++) driveQuarter(-1);
        checkSettled("partial");
        applyStimulus("after_partial", 0, 1, QPD - 1);

        applyStimulus("collide", 2, 1, QPD - 1);
        applyStimulus("sec_cw", 0, 1, QPD - 1);
        applyStimulus("press_armed", 1, 0, 0);
        applyStimulus("armed_ccw", 0, -1, QPD - 1);
        applyStimulus("armed_cw1", 0, 1, QPD - 1);
        applyStimulus("armed_cw2", 0, 1, QPD - 1);
        applyStimulus("press_load", 1, 0, 0);
        checkOutput("load_count", loadCount, expLoads);

        applyStimulus("press_sec", 1, 0, 0);
        for (int i = 0; i < 60 && mSec != 57; i++) begin
            idle(200);
            applyStimulus("sec_slow", 0, -1, QPD - 1);
        end
        idle(200);
        applyStimulus("acc1", 0, 1, QPD - 1);
        idle(40);
        applyStimulus("acc2", 0, 1, QPD - 1);
        idle(200);
        applyStimulus("acc3", 0, 1, QPD - 1);

        // Reset lands mid-detent and between the press and its load pulse.
        applyStimulus("press_arm2", 1, 0, 0);
        for (int i = 0; i < 3; i++) driveQuarter(1);
        @(negedge clk);
        BTN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        idle(2);
        checkOutput("rst2_min", int'(minO), 0);
        checkOutput("rst2_sec", int'(secO), 0);
        checkOutput("rst2_state", int'(stateO), 0);
        checkOutput("rst2_led", int'(ledO), 0);
        checkOutput("rst2_load", int'(loadO), 0);
        reset = 1'b1;
        idle(3);
        checkOutput("held_btn_state", int'(stateO), mState);
        checkOutput("abort_load_count", loadCount, expLoads);
        BTN = 1'b0;
        driveQuarter(1);
        idle(2);
        checkOutput("probe_min", int'(minO), mMin);
        applyStimulus("post_rst", 0, 1, QPD - 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
